// File: rtl/trigger_debounce.sv
// Push-button conditioner: two-flop synchroniser, debouncer and press FSM that
// emits a one-cycle trigger per confirmed press and a one-cycle long_press pulse.
module trigger_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] HOLD_CYCLES     = 24'd1500000,
  parameter int          CNT_W           = 24
) (
  input  logic m_clk,
  input  logic m_reset,
  input  logic btn_raw,
  output logic trigger,
  output logic long_press,
  output logic btn_level
);

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 16'd1);
  localparam logic [CNT_W-1:0] DEB_INIT  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 24'd1);

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] hold_cnt;

  always_ff @(posedge m_clk or posedge m_reset) begin
    if (m_reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // hold_cnt is preloaded with DEBOUNCE_CYCLES on press, so long_press counts
  // from the first high sample rather than from the confirmed press.
  always_ff @(posedge m_clk or posedge m_reset) begin
    if (m_reset) begin
      state      <= RELEASED;
      deb_cnt    <= '0;
      hold_cnt   <= '0;
      trigger    <= 1'b0;
      long_press <= 1'b0;
      btn_level  <= 1'b0;
    end else begin
      trigger    <= 1'b0;
      long_press <= 1'b0;
      case (state)
        RELEASED: begin
          if (sync2) begin
            if (deb_cnt == DEB_LAST) begin
              state     <= PRESSED;
              btn_level <= 1'b1;
              trigger   <= 1'b1;
              deb_cnt   <= '0;
              hold_cnt  <= DEB_INIT;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end else begin
            deb_cnt <= '0;
          end
        end
        PRESSED, HELD: begin
          if (!sync2) begin
            if (deb_cnt == DEB_LAST) begin
              state     <= RELEASED;
              btn_level <= 1'b0;
              deb_cnt   <= '0;
              hold_cnt  <= '0;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end else begin
            deb_cnt <= '0;
            if (state == PRESSED) begin
              if (hold_cnt == HOLD_LAST) begin
                state      <= HELD;
                long_press <= 1'b1;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
          end
        end
        default: begin
          state     <= RELEASED;
          deb_cnt   <= '0;
          hold_cnt  <= '0;
          btn_level <= 1'b0;
        end
      endcase
    end
  end

endmodule
